// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory-access stage: MemRW, data size, branch kind and FSM state.
// The execute stage decodes into the same MemRW/dsize/MemBranch values.
package mem_access_pkg;

   typedef enum logic [1:0] {
      MEM_NONE  = 2'b00,
      MEM_LOAD  = 2'b01,
      MEM_STORE = 2'b10,
      MEM_RSVD  = 2'b11
   } mem_rw_e;

   typedef enum logic [1:0] {
      DSIZE_B    = 2'b00,
      DSIZE_H    = 2'b01,
      DSIZE_W    = 2'b10,
      DSIZE_RSVD = 2'b11
   } dsize_e;

   typedef enum logic [2:0] {
      BR_NONE = 3'b000,
      BR_EQ   = 3'b001,
      BR_NE   = 3'b010,
      BR_LT   = 3'b011,
      BR_GE   = 3'b100,
      BR_LTU  = 3'b101,
      BR_GEU  = 3'b110,
      BR_JMP  = 3'b111
   } br_e;

   typedef enum logic {
      StIdle = 1'b0,
      StWait = 1'b1
   } state_e;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        we;
   } dmem_cmd_t;

   function automatic logic is_memop(input logic [1:0] rw);
      return (rw == MEM_LOAD) || (rw == MEM_STORE);
   endfunction

endpackage

// File: rtl/mem_access_lsu_align.sv
// Combinational byte-lane steering: byte enables, replicated store data, load lane select
// with sign/zero extension, and misalignment detection.
module lsu_align
   import mem_access_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [31:0] store_data,
   input  logic [31:0] read_data,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] rdata_ext,
   output logic        misalign
);

   logic [31:0] lane;

   assign lane = read_data >> {addr_lo, 3'b000};

   always_comb begin
      be        = 4'b0000;
      wdata     = 32'h0;
      rdata_ext = 32'h0;
      misalign  = 1'b0;
      case (dsize_e'(size))
         DSIZE_B: begin
            be        = 4'b0001 << addr_lo;
            wdata     = {4{store_data[7:0]}};
            rdata_ext = {{24{~is_unsigned & lane[7]}}, lane[7:0]};
         end
         DSIZE_H: begin
            be        = 4'b0011 << addr_lo;
            wdata     = {2{store_data[15:0]}};
            rdata_ext = {{16{~is_unsigned & lane[15]}}, lane[15:0]};
            misalign  = addr_lo[0];
         end
         // Reserved size decodes as a word access.
         default: begin
            be        = 4'b1111;
            wdata     = store_data;
            rdata_ext = read_data;
            misalign  = |addr_lo;
         end
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// MEM stage of the RV32I pipeline: data-memory req/ack FSM, branch resolution and the
// MEM/WB pipeline register.
module mem_access
   import mem_access_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ALU_co_pype,
   input  logic [31:0] read_data2_pype2,
   input  logic [31:0] PCBranch_pype2,
   input  logic [31:0] PCp4_pype2,
   input  logic [4:0]  WReg_pype2,
   input  logic        RegWrite_pype2,
   input  logic [1:0]  MemtoReg_pype2,
   input  logic [1:0]  MemRW_pype2,
   input  logic [2:0]  MemBranch_pype2,
   input  logic [1:0]  dsize_pype2,
   input  logic [31:0] Instraction_pype2,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        mem_keep,
   output logic        branch_taken,
   output logic [31:0] branch_PC,
   output logic        misalign,
   output logic [31:0] read_data_pype3,
   output logic [31:0] ALU_co_pype3,
   output logic [31:0] PCp4_pype3,
   output logic [4:0]  WReg_pype3,
   output logic        RegWrite_pype3,
   output logic [1:0]  MemtoReg_pype3
);

   logic        memop;
   logic        is_load;
   logic        access;
   logic        misalign_raw;
   logic [3:0]  lane_be;
   logic [31:0] lane_wdata;
   logic [31:0] rdata_ext;
   logic        unused_instr;
   dmem_cmd_t   cmd_now;
   dmem_cmd_t   cmd_q;
   state_e      state_q;
   state_e      state_d;

   assign unused_instr = ^{Instraction_pype2[31:15], Instraction_pype2[13:0]};

   lsu_align u_lsu_align (
      .addr_lo     (ALU_co_pype[1:0]),
      .size        (dsize_pype2),
      .is_unsigned (Instraction_pype2[14]),
      .store_data  (read_data2_pype2),
      .read_data   (dmem_rdata),
      .be          (lane_be),
      .wdata       (lane_wdata),
      .rdata_ext   (rdata_ext),
      .misalign    (misalign_raw)
   );

   assign memop    = is_memop(MemRW_pype2);
   assign is_load  = (MemRW_pype2 == MEM_LOAD);
   assign access   = memop & ~misalign_raw;
   assign misalign = memop & misalign_raw;
   assign mem_keep = access & ~dmem_ack;

   always_comb begin
      cmd_now.addr  = {ALU_co_pype[31:2], 2'b00};
      cmd_now.be    = lane_be;
      cmd_now.wdata = lane_wdata;
      cmd_now.we    = (MemRW_pype2 == MEM_STORE);
   end

   // WAIT replays the command latched at issue so the bus stays stable regardless of inputs.
   always_comb begin
      state_d    = state_q;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      dmem_addr  = 32'h0;
      dmem_be    = 4'b0000;
      dmem_wdata = 32'h0;
      unique case (state_q)
         StIdle: begin
            if (access) begin
               dmem_req   = 1'b1;
               dmem_we    = cmd_now.we;
               dmem_addr  = cmd_now.addr;
               dmem_be    = cmd_now.be;
               dmem_wdata = cmd_now.wdata;
               if (!dmem_ack) state_d = StWait;
            end
         end
         StWait: begin
            dmem_req   = 1'b1;
            dmem_we    = cmd_q.we;
            dmem_addr  = cmd_q.addr;
            dmem_be    = cmd_q.be;
            dmem_wdata = cmd_q.wdata;
            if (dmem_ack) state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cmd_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == StIdle && access) cmd_q <= cmd_now;
      end
   end

   always_comb begin
      branch_taken = 1'b0;
      unique case (br_e'(MemBranch_pype2))
         BR_NONE:         branch_taken = 1'b0;
         BR_EQ:           branch_taken = (ALU_co_pype == 32'h0);
         BR_NE:           branch_taken = (ALU_co_pype != 32'h0);
         BR_LT,  BR_LTU:  branch_taken = ALU_co_pype[0];
         BR_GE,  BR_GEU:  branch_taken = ~ALU_co_pype[0];
         BR_JMP:          branch_taken = 1'b1;
      endcase
   end

   assign branch_PC = PCBranch_pype2;

   // MEM/WB: a stalled or misaligned cycle loads a bubble, the ack cycle loads the result.
   always_ff @(posedge clk) begin
      if (rst || mem_keep || misalign) begin
         read_data_pype3 <= 32'h0;
         ALU_co_pype3    <= 32'h0;
         PCp4_pype3      <= 32'h0;
         WReg_pype3      <= 5'd0;
         RegWrite_pype3  <= 1'b0;
         MemtoReg_pype3  <= 2'b00;
      end else begin
         read_data_pype3 <= is_load ? rdata_ext : 32'h0;
         ALU_co_pype3    <= ALU_co_pype;
         PCp4_pype3      <= PCp4_pype2;
         WReg_pype3      <= WReg_pype2;
         RegWrite_pype3  <= RegWrite_pype2;
         MemtoReg_pype3  <= MemtoReg_pype2;
      end
   end

endmodule
